// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU use radix-2 shift-add (LSB first), DIV/DIVU use restoring division
// (MSB first). Both run on magnitudes; signs are reapplied in the FIX state.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data_in,
  input  logic [WIDTH-1:0] rt_data_in,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Magnitude of an operand; only signed ops take the absolute value.
  // 0x8000_0000 negates to itself, which read as unsigned is exactly 2**31.
  function automatic logic [WIDTH-1:0] abs_sel(input logic signed [WIDTH-1:0] x,
                                               input logic is_signed);
    logic signed [WIDTH-1:0] neg_x;
    neg_x = -x;
    return (is_signed && x[WIDTH-1]) ? neg_x : x;
  endfunction

  // Conditional two's-complement negation, single width.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? -x : x;
  endfunction

  // Conditional two's-complement negation, double width.
  function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
    return neg ? -x : x;
  endfunction

  // Control state
  logic [1:0]       state;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  // Datapath state: md is the multiplicand or divisor, sh is the operand that
  // is consumed one bit per iteration (multiplier or dividend).
  logic [WIDTH-1:0]   md;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   rs_orig;
  logic [2*WIDTH-1:0] acc;

  // Iteration step
  logic [WIDTH:0]     mul_pp;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   sh_next;

  // Final sign-corrected results
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // One iteration: acc high half is the running partial product / remainder.
  always_comb begin
    mul_pp   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (sh[0] ? {1'b0, md} : '0);
    div_sh   = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, md};
    acc_next = acc;
    sh_next  = sh;
    if (op_r[1]) begin
      // Restoring divide: keep the difference when it does not borrow.
      if (!div_diff[WIDTH+1]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
      sh_next = {sh[WIDTH-2:0], 1'b0};
    end else begin
      // Shift-add multiply: product bits fall into the low half LSB first.
      acc_next = {mul_pp, acc[WIDTH-1:1]};
      sh_next  = {1'b0, sh[WIDTH-1:1]};
    end
  end

  // Sign correction applied when the result is committed.
  always_comb begin
    prod_fix = cond_neg_dw(acc, q_neg);
    quo_fix  = cond_neg_w(acc[WIDTH-1:0], q_neg);
    rem_fix  = cond_neg_w(acc[2*WIDTH-1:WIDTH], r_neg);
  end

  // FSM, HI/LO and done pulse; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_r     <= 2'b00;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            op_r     <= op;
            cnt      <= '0;
            q_neg    <= op[0] & (rs_data_in[WIDTH-1] ^ rt_data_in[WIDTH-1]);
            r_neg    <= op[0] & rs_data_in[WIDTH-1];
            div_zero <= (rt_data_in == '0);
          end else begin
            // Moves only land when no operation is being launched.
            if (mthi) hi_q <= rs_data_in;
            if (mtlo) lo_q <= rs_data_in;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!op_r[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= rs_orig;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand capture at launch and per-iteration datapath update.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      acc     <= '0;
      rs_orig <= rs_data_in;
      if (op[1]) begin
        md <= abs_sel(rt_data_in, op[0]);
        sh <= abs_sel(rs_data_in, op[0]);
      end else begin
        md <= abs_sel(rs_data_in, op[0]);
        sh <= abs_sel(rt_data_in, op[0]);
      end
    end else if (state == S_RUN) begin
      acc <= acc_next;
      sh  <= sh_next;
    end
  end

  assign busy   = (state != S_IDLE);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random MULT/DIV/MTHI/MTLO sequences for md_unit,
// checked against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data_in;
  logic [31:0] rt_data_in;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_vec = 0;
  int n_err = 0;

  md_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs_data_in (rs_data_in),
    .rt_data_in (rt_data_in),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin
        p = sa * sb;
        return p;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Launch one op; optionally inject mthi (kind 0) or start (kind 1) while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int inj_kind, input bit with_mtlo);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int k;
    bit seen;
    exp = model(o, a, b);
    @(negedge clk);
    hi0 = hi_out;
    lo0 = lo_out;
    op = o; rs_data_in = a; rt_data_in = b; start = 1'b1; mtlo = with_mtlo;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    check("busy_after_start", busy, 1);
    check("hi_held_at_start", hi_out, hi0);
    check("lo_held_at_start", lo_out, lo0);
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      if (k == inj_cyc) begin
        if (inj_kind == 0) begin
          mthi = 1'b1; rs_data_in = 32'h0000_1234;
        end else begin
          start = 1'b1; op = ~o; rs_data_in = $urandom; rt_data_in = $urandom;
        end
      end
      @(posedge clk); #1;
      k++;
      mthi = 1'b0; start = 1'b0;
      if (k == inj_cyc + 1) begin
        check("hi_held_busy", hi_out, hi0);
        check("lo_held_busy", lo_out, lo0);
      end
      if (done) seen = 1;
    end
    check("latency", k, 33);
    if (seen) begin
      check("hi_result", hi_out, exp[63:32]);
      check("lo_result", lo_out, exp[31:0]);
      check("busy_in_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_pulse", done, 0);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0;
    rs_data_in = '0; rt_data_in = '0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk) reset = 1'b1;

    // Idle moves
    @(negedge clk); mthi = 1'b1; rs_data_in = 32'hA5A5_5A5A;
    @(posedge clk); #1; mthi = 1'b0;
    check("mthi_hi", hi_out, 32'hA5A5_5A5A);
    check("mthi_lo_untouched", lo_out, 0);
    check("mthi_no_done", done, 0);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; rs_data_in = 32'h0BAD_F00D;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    check("both_hi", hi_out, 32'h0BAD_F00D);
    check("both_lo", lo_out, 32'h0BAD_F00D);

    // Directed arithmetic and boundary cases
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0);
    run_op(2'd1, 32'hFFFF_FFFE, 32'h0000_0003, -1, 0, 0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, -1, 0, 0);
    run_op(2'd2, 32'h0000_0007, 32'h0000_0000, -1, 0, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0);
    run_op(2'd3, 32'h8000_0000, 32'h0000_0000, -1, 0, 0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, -1, 0, 0);

    // Conflicts: move while busy, start+mtlo together, start while busy
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 0);
    run_op(2'd0, 32'h1234_5678, 32'h0000_0009, -1, 0, 1);
    run_op(2'd1, 32'hFFFF_0001, 32'h0000_7777, 12, 1, 0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 3) rb = 32'd0;
      else if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
      run_op(ro, ra, rb, -1, 0, 0);
    end

    // Asynchronous reset in the middle of a divide
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; rs_data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk); op = 2'd3; rs_data_in = 32'd100; rt_data_in = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_hi", hi_out, 0);
    check("abort_lo", lo_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", busy, 0);
    run_op(2'd0, 32'd3, 32'd5, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
